// File: rtl/uart_pkg.sv
// Shared UART defaults; the receiver and its receive buffer both size themselves from these.
package uart_pkg;
    localparam int UART_DATA_BITS     = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;
    localparam int UART_ERR_CNT_W     = 8;
endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock circular FIFO with show-ahead read and wrap-bit pointers.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_BITS,
    parameter int DEPTH = UART_RX_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [PW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; contents are meaningless until pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count = wr_ptr - rd_ptr;
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: byte FIFO plus overrun / framing-error bookkeeping.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int DEPTH       = UART_RX_FIFO_DEPTH,
    parameter int AFULL_LEVEL = 12,
    parameter int ERR_CNT_W   = UART_ERR_CNT_W,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_ferr,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [CW-1:0]        count,
    output logic                 full,
    output logic                 almost_full,
    output logic                 overrun,
    output logic                 ferr_sticky,
    output logic [ERR_CNT_W-1:0] ferr_count,
    input  logic                 clr_flags
);
    localparam logic [CW-1:0]        AFULL_THR = CW'(AFULL_LEVEL);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX   = '1;

    logic empty;
    logic push;
    logic pop;
    logic drop;
    logic ferr_q;
    logic ferr_evt;

    assign rd_valid    = !empty;
    assign pop         = rd_valid & rd_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a byte then.
    assign push        = in_valid & (!full | pop);
    assign drop        = in_valid & full & !pop;
    assign ferr_evt    = in_ferr & !ferr_q;
    assign almost_full = (count >= AFULL_THR);

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .rdata (rd_data),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    // New events take priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ferr_q      <= 1'b0;
            overrun     <= 1'b0;
            ferr_sticky <= 1'b0;
            ferr_count  <= '0;
        end else begin
            ferr_q <= in_ferr;

            if (drop)           overrun <= 1'b1;
            else if (clr_flags) overrun <= 1'b0;

            if (ferr_evt) begin
                ferr_sticky <= 1'b1;
                if (clr_flags)                 ferr_count <= ERR_CNT_W'(1);
                else if (ferr_count != CNT_MAX) ferr_count <= ferr_count + 1'b1;
            end else if (clr_flags) begin
                ferr_sticky <= 1'b0;
                ferr_count  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;
    localparam int EW    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ferr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [CW-1:0] count;
    logic          full;
    logic          almost_full;
    logic          overrun;
    logic          ferr_sticky;
    logic [EW-1:0] ferr_count;
    logic          clr_flags;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    bit            m_ovr;
    bit            m_fs;
    int            m_fc;
    bit            m_prev;

    uart_rx_fifo #(
        .DATA_BITS   (DW),
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (AFULL),
        .ERR_CNT_W   (EW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ferr     (in_ferr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .count       (count),
        .full        (full),
        .almost_full (almost_full),
        .overrun     (overrun),
        .ferr_sticky (ferr_sticky),
        .ferr_count  (ferr_count),
        .clr_flags   (clr_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovr  = 0;
        m_fs   = 0;
        m_fc   = 0;
        m_prev = 0;
    endtask

    task automatic check_state();
        chk("count", 32'(count), 32'(m_q.size()));
        chk("full", 32'(full), 32'(m_q.size() == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(m_q.size() >= AFULL));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("ferr_sticky", 32'(ferr_sticky), 32'(m_fs));
        chk("ferr_count", 32'(ferr_count), 32'(m_fc));
        chk("rd_valid", 32'(rd_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("rd_data", 32'(rd_data), 32'(m_q[0]));
    endtask

    // One clock: predict from current inputs, advance, then compare.
    task automatic tick();
        bit pop, push, drop, evt;
        pop  = rd_ready && (m_q.size() != 0);
        push = in_valid && ((m_q.size() < DEPTH) || pop);
        drop = in_valid && !push;
        evt  = in_ferr && !m_prev;
        @(posedge clk);
        #1;
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(in_data);
        m_prev = in_ferr;
        if (drop)           m_ovr = 1;
        else if (clr_flags) m_ovr = 0;
        if (evt) begin
            m_fs = 1;
            m_fc = clr_flags ? 1 : ((m_fc == CMAX) ? CMAX : m_fc + 1);
        end else if (clr_flags) begin
            m_fs = 0;
            m_fc = 0;
        end
        check_state();
    endtask

    task automatic push_byte(input logic [DW-1:0] b);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_ferr   = 1'b0;
        rd_ready  = 1'b0;
        clr_flags = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check_state();

        // Single byte
        push_byte(8'hA5);
        chk("a5_data", 32'(rd_data), 32'h0A5);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;

        // Fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) push_byte(DW'(i));
        chk("full_at_16", 32'(full), 32'd1);
        push_byte(8'hFF);
        chk("overrun_set", 32'(overrun), 32'd1);
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", 32'(rd_data), 32'(i));
            tick();
        end
        rd_ready = 1'b0;
        tick();
        pulse_clr();

        // Simultaneous push and pop at full
        for (int i = 0; i < DEPTH; i++) push_byte(DW'(i));
        rd_ready = 1'b1;
        push_byte(8'h55);
        rd_ready = 1'b0;
        chk("full_pushpop_cnt", 32'(count), 32'(DEPTH));
        chk("full_pushpop_ovr", 32'(overrun), 32'd0);
        rd_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        rd_ready = 1'b0;

        // Random stream with backpressure, many pointer wraps
        begin
            int sent = 0;
            for (int cyc = 0; cyc < 2000 && (sent < 40 || m_q.size() != 0); cyc++) begin
                rd_ready = 1'($urandom_range(0, 2) != 0);
                in_valid = (sent < 40) && ($urandom_range(0, 1) == 1) && (m_q.size() < DEPTH);
                in_data  = DW'($urandom);
                if (in_valid) sent++;
                tick();
            end
            in_valid = 1'b0;
            rd_ready = 1'b0;
            chk("stream_sent", 32'(sent), 32'd40);
            chk("stream_empty", 32'(rd_valid), 32'd0);
        end

        // Framing-error edge counting and clear priority
        in_ferr = 1'b1;
        repeat (50) tick();
        in_ferr = 1'b0;
        tick();
        in_ferr = 1'b1;
        repeat (3) tick();
        in_ferr = 1'b0;
        tick();
        chk("ferr_two", 32'(ferr_count), 32'd2);
        pulse_clr();
        chk("ferr_cleared", 32'(ferr_count), 32'd0);
        in_ferr   = 1'b1;
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        in_ferr   = 1'b0;
        tick();
        chk("clr_vs_evt", 32'(ferr_count), 32'd1);

        // Saturation
        for (int i = 0; i < 300; i++) begin
            in_ferr = 1'b1;
            tick();
            in_ferr = 1'b0;
            tick();
        end
        chk("ferr_sat", 32'(ferr_count), 32'(CMAX));

        // Asynchronous reset with data in flight
        for (int i = 0; i < 5; i++) push_byte(DW'(8'h30 + i));
        chk("pre_rst_cnt", 32'(count), 32'd5);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_state();
        #2 rst_n = 1'b1;
        push_byte(8'h3C);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
